// File: rtl/bcd_digit_counter_pkg.sv
// ============================================================================
//  Module   : bcd_digit_counter_pkg
//  Brief    : Shared BCD digit type, digit limits and validity helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_digit_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter_cell.sv
// ============================================================================
//  Module   : bcd_digit_cell
//  Brief    : One BCD digit register with load, up/down step and wrap flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell
    import bcd_digit_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic dn,
    input  logic load,
    input  bcd_t value,
    output bcd_t digit,
    output logic wrap
);

    bcd_t r_digit;
    logic w_at_edge;

    assign w_at_edge = dn ? (r_digit == BCD_MIN) : (r_digit == BCD_MAX);
    assign wrap      = step & w_at_edge;
    assign digit     = r_digit;

    // The caller only ever presents a value that has passed bcd_valid().
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= BCD_MIN;
        end else if (load) begin
            r_digit <= value;
        end else if (step) begin
            if (dn) begin
                r_digit <= w_at_edge ? BCD_MAX : (r_digit - 4'd1);
            end else begin
                r_digit <= w_at_edge ? BCD_MIN : (r_digit + 4'd1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// ============================================================================
//  Module   : bcd_digit_counter
//  Brief    : Two-digit prescaled BCD counter; BCD_DOWN_EN adds the dn port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_counter
    import bcd_digit_counter_pkg::*;
#(
    parameter int TICK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic load,
    input  bcd_t ld_d1,
    input  bcd_t ld_d0,
`ifdef BCD_DOWN_EN
    input  logic dn,
`endif
    output bcd_t d1,
    output bcd_t d0,
    output logic co,
    output logic load_err
);

    localparam int               c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0]  c_PRESC_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0]  c_PRESC_ONE  = c_PW'(1);

    logic [c_PW-1:0] r_presc;
    logic            r_co;
    logic            r_load_err;

    logic w_dn;
    logic w_tick;
    logic w_ld_ok;
    logic w_cell_load;
    bcd_t w_val1;
    bcd_t w_val0;
    logic w_step;
    logic w_wrap0;
    logic w_wrap1;

`ifdef BCD_DOWN_EN
    assign w_dn = dn;
`else
    assign w_dn = 1'b0;
`endif

    assign w_tick  = en & (r_presc == c_PRESC_LAST);
    assign w_ld_ok = bcd_valid(ld_d1) & bcd_valid(ld_d0);

    // clr is folded into the cell load path as a load of 00; any load,
    // accepted or not, suppresses the step in that cycle.
    assign w_cell_load = clr | (load & w_ld_ok);
    assign w_val1      = clr ? BCD_MIN : ld_d1;
    assign w_val0      = clr ? BCD_MIN : ld_d0;
    assign w_step      = w_tick & ~clr & ~load;

    bcd_digit_cell u_ones (
        .clk   (clk),
        .rst   (rst),
        .step  (w_step),
        .dn    (w_dn),
        .load  (w_cell_load),
        .value (w_val0),
        .digit (d0),
        .wrap  (w_wrap0)
    );

    bcd_digit_cell u_tens (
        .clk   (clk),
        .rst   (rst),
        .step  (w_wrap0),
        .dn    (w_dn),
        .load  (w_cell_load),
        .value (w_val1),
        .digit (d1),
        .wrap  (w_wrap1)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : (r_presc + c_PRESC_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_co       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_co       <= w_wrap1;
            r_load_err <= load & ~w_ld_ok;
        end
    end

    assign co       = r_co;
    assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_digit_counter.sv
// ============================================================================
//  Module   : tb_bcd_digit_counter
//  Brief    : Scoreboard bench for bcd_digit_counter against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_digit_counter;

    localparam int c_TD = 4;

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d0;
        logic       co;
        logic       le;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] ld_d1 = 4'd0;
    logic [3:0] ld_d0 = 4'd0;
    logic       dn = 1'b0;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       co;
    logic       load_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference state: the count as a plain integer 0..99.
    int m_count = 0;
    int m_presc = 0;

    bcd_digit_counter #(.TICK_DIV(c_TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .ld_d1    (ld_d1),
        .ld_d0    (ld_d0),
`ifdef BCD_DOWN_EN
        .dn       (dn),
`endif
        .d1       (d1),
        .d0       (d0),
        .co       (co),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic i_rst, input logic i_en, input logic i_clr,
                        input logic i_load, input int i_l1, input int i_l0,
                        input logic i_dn);
        exp_t e;
        logic tick;
        logic down;
        @(negedge clk);
        rst = i_rst; en = i_en; clr = i_clr; load = i_load;
        ld_d1 = 4'(i_l1); ld_d0 = 4'(i_l0); dn = i_dn;
`ifdef BCD_DOWN_EN
        down = i_dn;
`else
        down = 1'b0;
`endif
        e.co = 1'b0;
        e.le = 1'b0;
        if (i_rst || i_clr) begin
            m_count = 0;
            m_presc = 0;
        end else begin
            tick = i_en && (m_presc == c_TD - 1);
            if (i_en) m_presc = tick ? 0 : m_presc + 1;
            if (i_load) begin
                if (i_l1 <= 9 && i_l0 <= 9) m_count = i_l1 * 10 + i_l0;
                else e.le = 1'b1;
            end else if (tick) begin
                if (down) begin
                    e.co = (m_count == 0);
                    m_count = (m_count + 99) % 100;
                end else begin
                    e.co = (m_count == 99);
                    m_count = (m_count + 1) % 100;
                end
            end
        end
        e.d1 = 4'(m_count / 10);
        e.d0 = 4'(m_count % 10);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic i_en, input logic i_dn);
        for (int i = 0; i < n; i++) step(1'b0, i_en, 1'b0, 1'b0, 0, 0, i_dn);
    endtask

    // Monitor: outputs are valid every cycle, one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (d1 !== e.d1 || d0 !== e.d0 || co !== e.co || load_err !== e.le) begin
                    n_err++;
                    $display("FAIL outputs cyc %0d: got d1=%0d d0=%0d co=%b load_err=%b, expected d1=%0d d0=%0d co=%b load_err=%b",
                             cyc, d1, d0, co, load_err, e.d1, e.d0, e.co, e.le);
                end
            end
        end
    end

    initial begin
        logic r, c, l, e, dd;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        // Forty enabled edges from 00 with a divider of 4 lands on 10.
        run(40, 1'b1, 1'b0);
        // Load 98 and run through 99 to the wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 9, 8, 1'b0);
        run(10, 1'b1, 1'b0);
        // Rejected load, then a good one.
        step(1'b0, 1'b0, 1'b0, 1'b1, 3, 12, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3, 7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 15, 0, 1'b0);
        // Down through 00 to 99, then back up through the wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0);
        run(8, 1'b1, 1'b1);
        run(4, 1'b1, 1'b0);
        // Hold with prescaler mid-way.
        run(2, 1'b1, 1'b0);
        run(10, 1'b0, 1'b0);
        run(4, 1'b1, 1'b0);
        // clr colliding with load and a tick, then rst mid-run.
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, 5, 1'b0);
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 6, 6, 1'b0);
        run(6, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0);
        // Tick coinciding with a load, both accepted and rejected.
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 9, 9, 1'b0);
        run(3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 10, 3, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 24) == 0);
            e  = ($urandom_range(0, 9) < 8);
            dd = ($urandom_range(0, 99) < 50);
            step(r, e, c, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), dd);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
